// File: rtl/axi_interconnect_crossbar_sreq_arbit_pkg.sv
// ----------------------------------------------------------------------------
// axi_interconnect_defs
//   Shared definitions for the crossbar request-side schedulers.
//   - LOG2        : ceiling log2, used to size counters and index fields
//   - QOS_W       : width of one requester's QoS field
//   - TAG_*       : field layout of the routing tag {grant one-hot, ID}
//   - sreq_state_e: scheduler output-slot state
// ----------------------------------------------------------------------------
package axi_interconnect_defs;

    localparam int QOS_W      = 4;
    localparam int TAG_ID_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,   // output slot empty
        ST_BUSY = 1'b1    // m_req_valid high, waiting for m_req_ready
    } sreq_state_e;

    // Ceiling log2; LOG2(1) = 0.
    function automatic int LOG2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // The one-hot grant sits directly above the ID field.
    function automatic int TAG_OH_LSB(input int width_id);
        return width_id;
    endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_sreq_arbit_if.sv
// ----------------------------------------------------------------------------
// axi_interconnect_crossbar_sreq_arbit_if
//   Bundles the request-scheduler signals of one crossbar slave port.
//   Upstream  : s_req_info / s_req_qos / s_req_valid -> s_req_ready
//   Downstream: m_req_info / m_req_valid <- m_req_ready
//   Completion: resp_done (1-cycle pulse per finished transaction)
//   Tag push  : req_wren / req_id into the response-ordering queue
//   Status    : outstd_cnt (in-flight count), state_dbg (scheduler state)
//   Modports  : slave  = the scheduler itself
//               master = the surrounding requesters / downstream / response side
//
//   Handshake rule for both s_req and m_req: a transfer occurs on a rising
//   clk_sys edge where valid and ready are both high. A source keeps valid and
//   its payload stable until that edge; ready may depend combinationally on
//   valid (s_req_ready does), but valid never depends on ready.
// ----------------------------------------------------------------------------
interface axi_interconnect_crossbar_sreq_arbit_if
    import axi_interconnect_defs::*;
#(
    parameter int NUM_MASTER      = 4,
    parameter int WIDTH_ID        = 4,
    parameter int WIDTH_REQINFO   = 64,
    parameter int NUM_OUTSTANDING = 4
);
    localparam int CNT_W = LOG2(NUM_OUTSTANDING) + 1;

    logic [NUM_MASTER*WIDTH_REQINFO-1:0] s_req_info;
    logic [NUM_MASTER*QOS_W-1:0]         s_req_qos;
    logic [NUM_MASTER-1:0]               s_req_valid;
    logic [NUM_MASTER-1:0]               s_req_ready;
    logic [WIDTH_REQINFO-1:0]            m_req_info;
    logic                                m_req_valid;
    logic                                m_req_ready;
    logic                                resp_done;
    logic                                req_wren;
    logic [NUM_MASTER+WIDTH_ID-1:0]      req_id;
    logic [CNT_W-1:0]                    outstd_cnt;
    sreq_state_e                         state_dbg;

    modport slave (
        input  s_req_info, s_req_qos, s_req_valid, m_req_ready, resp_done,
        output s_req_ready, m_req_info, m_req_valid, req_wren, req_id,
               outstd_cnt, state_dbg
    );

    modport master (
        output s_req_info, s_req_qos, s_req_valid, m_req_ready, resp_done,
        input  s_req_ready, m_req_info, m_req_valid, req_wren, req_id,
               outstd_cnt, state_dbg
    );

endinterface

// File: rtl/axi_interconnect_rr_pick.sv
// ----------------------------------------------------------------------------
// axi_interconnect_rr_pick
//   Combinational round-robin picker: selects the first asserted request at
//   or after ptr, wrapping modulo N. Shared by the address and W schedulers.
//   req     in  N   request vector
//   ptr     in  PW  round-robin start position (0..N-1)
//   gnt_oh  out N   one-hot grant (zero when no request)
//   gnt_idx out PW  index of the grant
//   gnt_vld out 1   any request present
// ----------------------------------------------------------------------------
module axi_interconnect_rr_pick
    import axi_interconnect_defs::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? LOG2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Two passes: first the upper segment [ptr..N-1], then the wrapped
    // segment [0..ptr-1]; the first hit wins.
    always_comb begin
        logic found;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                gnt_oh[j] = 1'b1;
                gnt_idx   = PW'(j);
                found     = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt_oh[j] = 1'b1;
                gnt_idx   = PW'(j);
                found     = 1'b1;
            end
        end
        gnt_vld = found;
    end

endmodule

// File: rtl/axi_interconnect_crossbar_sreq_arbit.sv
// ----------------------------------------------------------------------------
// axi_interconnect_crossbar_sreq_arbit
//   Request-side scheduler for one crossbar slave port (AR or AW channel).
//   Round-robin arbitrates NUM_MASTER upstream requests onto one registered
//   downstream request, caps in-flight transactions at NUM_OUTSTANDING and
//   pushes a routing tag {grant one-hot, ID} on every accepted grant.
//   Ports:
//     clk_sys  in  system clock
//     rst_n    in  asynchronous active-low reset
//     bus      slave modport of axi_interconnect_crossbar_sreq_arbit_if
//   Build option:
//     AXI_IC_SREQ_QOS_EN - when defined, only valid requesters carrying the
//     highest s_req_qos compete in the round-robin; otherwise s_req_qos is
//     ignored.
// ----------------------------------------------------------------------------
module axi_interconnect_crossbar_sreq_arbit
    import axi_interconnect_defs::*;
#(
    parameter int NUM_MASTER      = 4,
    parameter int WIDTH_ID        = 4,
    parameter int WIDTH_REQINFO   = 64,
    parameter int NUM_OUTSTANDING = 4
) (
    input  logic                                  clk_sys,
    input  logic                                  rst_n,
    axi_interconnect_crossbar_sreq_arbit_if.slave bus
);

    localparam int WIDTH_OUTSTANDING = LOG2(NUM_OUTSTANDING);
    localparam int CNT_W             = WIDTH_OUTSTANDING + 1;
    localparam int PW                = (NUM_MASTER > 1) ? LOG2(NUM_MASTER) : 1;
    localparam int OH_LSB            = TAG_OH_LSB(WIDTH_ID);

    sreq_state_e              state;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            ptr_next;
    logic [CNT_W-1:0]         cnt;
    logic                     m_valid_q;
    logic [WIDTH_REQINFO-1:0] m_info_q;

    logic [NUM_MASTER-1:0]    cand;
    logic [NUM_MASTER-1:0]    gnt_oh;
    logic [PW-1:0]            gnt_idx;
    logic                     gnt_vld;
    logic                     load;
    logic [WIDTH_REQINFO-1:0] sel_info;

`ifdef AXI_IC_SREQ_QOS_EN
    // Candidates are the valid requesters tied at the highest QoS.
    always_comb begin
        logic [QOS_W-1:0] max_qos;
        max_qos = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (bus.s_req_valid[i] && (bus.s_req_qos[i*QOS_W +: QOS_W] > max_qos))
                max_qos = bus.s_req_qos[i*QOS_W +: QOS_W];
        end
        cand = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            cand[i] = bus.s_req_valid[i] && (bus.s_req_qos[i*QOS_W +: QOS_W] == max_qos);
        end
    end
`else
    logic unused_qos;
    assign unused_qos = ^bus.s_req_qos;
    assign cand       = bus.s_req_valid;
`endif

    axi_interconnect_rr_pick #(
        .N  (NUM_MASTER),
        .PW (PW)
    ) u_rr_pick (
        .req     (cand),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // rst_n gates load so nothing is accepted or tagged while reset is held.
    assign load = rst_n && gnt_vld && (cnt < CNT_W'(NUM_OUTSTANDING))
                  && ((state == ST_IDLE) || bus.m_req_ready);

    assign ptr_next = (int'(gnt_idx) == NUM_MASTER - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        sel_info = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (gnt_oh[i]) sel_info |= bus.s_req_info[i*WIDTH_REQINFO +: WIDTH_REQINFO];
        end
    end

    always_comb begin
        bus.req_id = '0;
        bus.req_id[OH_LSB +: NUM_MASTER]   = gnt_oh;
        bus.req_id[TAG_ID_LSB +: WIDTH_ID] = sel_info[WIDTH_ID-1:0];
    end

    assign bus.s_req_ready = load ? gnt_oh : '0;
    assign bus.req_wren    = load;
    assign bus.m_req_valid = m_valid_q;
    assign bus.m_req_info  = m_info_q;
    assign bus.outstd_cnt  = cnt;
    assign bus.state_dbg   = state;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m_valid_q <= 1'b0;
            m_info_q  <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
        end else begin
            // A load in BUSY implies m_req_ready, so the old beat leaves as
            // the new one enters the slot.
            if (load) begin
                state     <= ST_BUSY;
                m_valid_q <= 1'b1;
                m_info_q  <= sel_info;
                rr_ptr    <= ptr_next;
            end else if ((state == ST_BUSY) && bus.m_req_ready) begin
                state     <= ST_IDLE;
                m_valid_q <= 1'b0;
            end

            // Simultaneous load and completion cancel; completion at zero
            // is illegal and saturates.
            case ({load, bus.resp_done})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    resp_done_underflow: assert property (
        @(posedge clk_sys) disable iff (!rst_n) !(bus.resp_done && (cnt == '0))
    );

endmodule

// File: tb/tb_axi_interconnect_crossbar_sreq_arbit.sv
module tb_axi_interconnect_crossbar_sreq_arbit;
    import axi_interconnect_defs::*;

    localparam int NM = 4;
    localparam int WI = 4;
    localparam int WR = 64;
    localparam int NO = 4;

    // ---------------- clock / reset ----------------
    logic clk_sys;
    logic rst_n;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    axi_interconnect_crossbar_sreq_arbit_if #(
        .NUM_MASTER(NM), .WIDTH_ID(WI), .WIDTH_REQINFO(WR), .NUM_OUTSTANDING(NO)
    ) bus ();

    axi_interconnect_crossbar_sreq_arbit #(
        .NUM_MASTER(NM), .WIDTH_ID(WI), .WIDTH_REQINFO(WR), .NUM_OUTSTANDING(NO)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [NM+WI-1:0] exp_q[$];
    logic [WR-1:0]    info_q[$];
    logic [WI-1:0]    lane_id[NM];
    logic [WR-1:0]    lane_info[NM];
    int               seq;
    int               total;
    int               bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int i, input logic [WI-1:0] id);
        seq++;
        lane_id[i]   = id;
        lane_info[i] = {8'(i + 1), 24'hA5A5A5, 28'(seq), id};
        bus.s_req_info[i*WR +: WR] = lane_info[i];
    endtask

    task automatic expect_grant(input int g);
        exp_q.push_back({4'(1 << g), lane_id[g]});
        info_q.push_back(lane_info[g]);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.s_req_valid = '0;
        bus.s_req_qos   = '0;
        bus.m_req_ready = 1'b0;
        bus.resp_done   = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    // One clock: inputs were driven at the preceding negedge. Outputs are
    // sampled 2 time units later, then time advances to the next negedge.
    task automatic cycle(input logic [NM-1:0] exp_ready);
        logic [NM+WI-1:0] e_id;
        logic [WR-1:0]    e_info;
        #2;
        chk("s_req_ready", 64'(bus.s_req_ready), 64'(exp_ready));
        if (bus.req_wren) begin
            chk("tag_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e_id = exp_q.pop_front();
                chk("req_id", 64'(bus.req_id), 64'(e_id));
            end
        end
        if (bus.m_req_valid && bus.m_req_ready) begin
            chk("xfer_expected", 64'(info_q.size() != 0), 64'd1);
            if (info_q.size() != 0) begin
                e_info = info_q.pop_front();
                chk("m_req_info", bus.m_req_info, e_info);
            end
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        seq   = 0;
        bus.s_req_info  = '0;
        bus.s_req_qos   = '0;
        bus.m_req_ready = 1'b0;
        bus.resp_done   = 1'b0;
        for (int i = 0; i < NM; i++) set_lane(i, 4'($urandom_range(0, 15)));

        // Reset held with every requester valid.
        rst_n           = 1'b0;
        bus.s_req_valid = '1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        #2;
        chk("rst_s_req_ready", 64'(bus.s_req_ready), 64'd0);
        chk("rst_m_req_valid", 64'(bus.m_req_valid), 64'd0);
        chk("rst_req_wren",    64'(bus.req_wren),    64'd0);
        chk("rst_outstd_cnt",  64'(bus.outstd_cnt),  64'd0);
        chk("rst_m_req_info",  bus.m_req_info,       64'd0);
        chk("rst_state",       64'(bus.state_dbg),   64'(ST_IDLE));
        @(negedge clk_sys);

        // Fairness: all valid, downstream always ready, completions each cycle.
        do_reset();
        for (int i = 0; i < NM; i++) set_lane(i, 4'($urandom_range(0, 15)));
        bus.s_req_valid = 4'hF;
        bus.m_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.resp_done = (k != 0);
            expect_grant(k % NM);
            cycle(4'(1 << (k % NM)));
        end
        bus.s_req_valid = '0;
        bus.resp_done   = 1'b1;
        cycle(4'b0000);
        bus.resp_done = 1'b0;
        chk("fair_cnt_drained", 64'(bus.outstd_cnt), 64'd0);
        chk("fair_m_valid_low", 64'(bus.m_req_valid), 64'd0);

        // Limit: four grants, then blocked until one completion.
        do_reset();
        for (int i = 0; i < NM; i++) set_lane(i, 4'($urandom_range(0, 15)));
        bus.s_req_valid = 4'hF;
        bus.m_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_grant(k);
            cycle(4'(1 << k));
        end
        cycle(4'b0000);
        chk("limit_cnt_full", 64'(bus.outstd_cnt), 64'd4);
        cycle(4'b0000);
        bus.resp_done = 1'b1;
        cycle(4'b0000);
        bus.resp_done = 1'b0;
        chk("limit_cnt_freed", 64'(bus.outstd_cnt), 64'd3);
        expect_grant(0);
        cycle(4'b0001);
        cycle(4'b0000);
        chk("limit_cnt_refull", 64'(bus.outstd_cnt), 64'd4);

        // Backpressure: requester 2 (ID 0xA) granted, downstream stalls 5 cycles.
        do_reset();
        set_lane(0, 4'($urandom_range(0, 15)));
        set_lane(2, 4'hA);
        bus.s_req_valid = 4'b0100;
        bus.m_req_ready = 1'b0;
        expect_grant(2);
        cycle(4'b0100);
        bus.s_req_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0000);
            chk("bp_m_valid", 64'(bus.m_req_valid), 64'd1);
            chk("bp_m_info",  bus.m_req_info,       lane_info[2]);
            chk("bp_state",   64'(bus.state_dbg),   64'(ST_BUSY));
        end
        bus.m_req_ready = 1'b1;
        expect_grant(0);
        cycle(4'b0001);
        bus.s_req_valid = '0;
        cycle(4'b0000);
        chk("bp_idle", 64'(bus.state_dbg), 64'(ST_IDLE));

        // Simultaneous load and completion at count 2; lone requester wins.
        do_reset();
        set_lane(0, 4'($urandom_range(0, 15)));
        bus.s_req_valid = 4'b0001;
        bus.m_req_ready = 1'b1;
        expect_grant(0);
        cycle(4'b0001);
        expect_grant(0);
        cycle(4'b0001);
        chk("sim_cnt_two", 64'(bus.outstd_cnt), 64'd2);
        bus.resp_done = 1'b1;
        expect_grant(0);
        cycle(4'b0001);
        chk("sim_cnt_hold", 64'(bus.outstd_cnt), 64'd2);
        bus.s_req_valid = '0;
        cycle(4'b0000);
        cycle(4'b0000);
        bus.resp_done = 1'b0;
        chk("sim_cnt_zero", 64'(bus.outstd_cnt), 64'd0);

        // QoS: req0 qos=1, req3 qos=7, pointer at 0.
        do_reset();
        set_lane(0, 4'($urandom_range(0, 15)));
        set_lane(3, 4'($urandom_range(0, 15)));
        bus.s_req_qos   = 16'h7001;
        bus.s_req_valid = 4'b1001;
        bus.m_req_ready = 1'b1;
`ifdef AXI_IC_SREQ_QOS_EN
        expect_grant(3);
        cycle(4'b1000);
`else
        expect_grant(0);
        cycle(4'b0001);
`endif
        bus.s_req_valid = '0;
        cycle(4'b0000);

        chk("tags_all_seen", 64'(exp_q.size()),  64'd0);
        chk("xfers_all_seen", 64'(info_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
